// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal noise gate.
package pedal_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_t;

    localparam logic [8:0] GATE_GAIN_UNITY = 9'd256;
    localparam logic [8:0] GATE_ATK_STEP   = 9'd32;
    localparam logic [8:0] GATE_REL_STEP   = 9'd1;
    localparam int         GATE_ENV_SHIFT  = 4;

endpackage

// File: rtl/envelope_follower.sv
// Peak envelope follower: instant attack to |sample|, exponential decay by env>>GATE_ENV_SHIFT.
module envelope_follower
    import pedal_pkg::*;
(
    input  logic        clk_48,
    input  logic        rst_n,
    input  sample_t     i_sample,
    output logic [15:0] o_env
);

    logic [15:0] w_mag;
    logic [15:0] r_env;

    // -32768 has no positive counterpart in 16 bits, so it clips to 32767
    function automatic logic [15:0] abs_sat(input sample_t s);
        if (s == 16'sh8000)
            return 16'h7FFF;
        else if (s < 0)
            return $unsigned(-s);
        else
            return $unsigned(s);
    endfunction

    assign w_mag = abs_sat(i_sample);

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n)
            r_env <= '0;
        else if (w_mag > r_env)
            r_env <= w_mag;
        else
            r_env <= r_env - (r_env >> GATE_ENV_SHIFT);
    end

    assign o_env = r_env;

endmodule

// File: rtl/noise_gate.sv
// Noise gate with hysteresis, hold time and attack/release gain control.
// Define NOISE_GATE_RAMP_EN for ramped attack/release; otherwise gain switches in one sample.
module noise_gate
    import pedal_pkg::*;
(
    input  logic        clk_48,
    input  logic        rst_n,
    input  logic [31:0] x,
    output logic [31:0] y,
    input  logic        en,
    input  logic [15:0] threshold,
    input  logic [11:0] hold_len,
    output logic        gate_open
);

    sample_t     w_sample;
    sample_t     w_scaled;
    logic [15:0] w_env;
    logic        w_above;
    logic        w_below;
    logic [8:0]  w_gain_up;
    logic [8:0]  w_gain_dn;
    logic        w_atk_done;
    logic        w_rel_done;
    logic        w_unused_hi;

    gate_state_t r_state;
    logic [8:0]  r_gain;
    logic [11:0] r_hold_cnt;
    logic        r_gate_open;
    logic [31:0] r_y;

    // gain <= 256 bounds |x*gain| to 2^23, so the 25-bit product never wraps
    function automatic sample_t apply_gain(input sample_t s, input logic [8:0] g);
        logic signed [24:0] s_ext;
        logic signed [24:0] g_ext;
        logic signed [24:0] prod;
        s_ext = {{9{s[15]}}, s};
        g_ext = {16'd0, g};
        prod  = s_ext * g_ext;
        return sample_t'(prod >>> 8);
    endfunction

    assign w_sample    = $signed(x[15:0]);
    assign w_unused_hi = ^x[31:16];

    envelope_follower u_env (
        .clk_48   (clk_48),
        .rst_n    (rst_n),
        .i_sample (w_sample),
        .o_env    (w_env)
    );

    assign w_above = (w_env >= threshold);
    assign w_below = (w_env < (threshold >> 1));

`ifdef NOISE_GATE_RAMP_EN
    assign w_gain_up = (r_gain >= GATE_GAIN_UNITY - GATE_ATK_STEP) ? GATE_GAIN_UNITY
                                                                    : r_gain + GATE_ATK_STEP;
    assign w_gain_dn = (r_gain <= GATE_REL_STEP) ? 9'd0 : r_gain - GATE_REL_STEP;
`else
    assign w_gain_up = GATE_GAIN_UNITY;
    assign w_gain_dn = 9'd0;
`endif

    assign w_atk_done = (w_gain_up == GATE_GAIN_UNITY);
    assign w_rel_done = (w_gain_dn == 9'd0);
    assign w_scaled   = apply_gain(w_sample, r_gain);

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLOSED;
            r_gain      <= '0;
            r_hold_cnt  <= '0;
            r_gate_open <= 1'b0;
        end else if (!en) begin
            r_state     <= OPEN;
            r_gain      <= GATE_GAIN_UNITY;
            r_gate_open <= 1'b1;
        end else begin
            case (r_state)
                CLOSED: begin
                    r_gain <= '0;
                    if (w_above) begin
                        r_state     <= ATTACK;
                        r_gate_open <= 1'b1;
                    end
                end
                ATTACK: begin
                    r_gain <= w_gain_up;
                    if (w_atk_done)
                        r_state <= OPEN;
                end
                OPEN: begin
                    r_gain <= GATE_GAIN_UNITY;
                    if (w_below) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= hold_len;
                    end
                end
                HOLD: begin
                    if (w_above)
                        r_state <= OPEN;
                    else if (r_hold_cnt == 12'd0)
                        r_state <= RELEASE;
                    else
                        r_hold_cnt <= r_hold_cnt - 12'd1;
                end
                RELEASE: begin
                    // a retrigger resumes the attack from wherever the gain has fallen to
                    if (w_above) begin
                        r_state <= ATTACK;
                    end else begin
                        r_gain <= w_gain_dn;
                        if (w_rel_done) begin
                            r_state     <= CLOSED;
                            r_gate_open <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= CLOSED;
                    r_gain      <= '0;
                    r_gate_open <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n)
            r_y <= '0;
        else if (!en)
            r_y <= {{16{w_sample[15]}}, w_sample};
        else
            r_y <= {{16{w_scaled[15]}}, w_scaled};
    end

    assign y         = r_y;
    assign gate_open = r_gate_open;

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate; expectations follow the NOISE_GATE_RAMP_EN setting of the build.
`timescale 1ns/1ps
module tb_noise_gate;
    import pedal_pkg::*;

    logic        clk_48 = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic [31:0] x = 32'd0;
    logic [31:0] y;
    logic [15:0] threshold = 16'd1000;
    logic [11:0] hold_len = 12'd4;
    logic        gate_open;

    int n_checks = 0;
    int n_errors = 0;

`ifdef NOISE_GATE_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif
    localparam int HOLD_AT    = 36;
    localparam int REL_AT     = HOLD_AT + 5;
    localparam int REL_CYCLES = RAMP ? 256 : 1;
    localparam int FALL_AT    = REL_AT + REL_CYCLES;

    noise_gate dut (
        .clk_48    (clk_48),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .en        (en),
        .threshold (threshold),
        .hold_len  (hold_len),
        .gate_open (gate_open)
    );

    always #5 clk_48 = ~clk_48;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    function automatic logic [31:0] exp_atk_y(input int k);
        if (k <= 2) return 32'd0;
        if (!RAMP) return 32'd5000;
        return 32'(625 * (k - 2));
    endfunction

    function automatic gate_state_t exp_fall_state(input int j);
        if (j < HOLD_AT) return OPEN;
        if (j < REL_AT) return HOLD;
        if (j < FALL_AT) return RELEASE;
        return CLOSED;
    endfunction

    function automatic logic [31:0] exp_fall_gain(input int j);
        if (j <= REL_AT) return 32'd256;
        if (j >= FALL_AT) return 32'd0;
        return 32'(256 - (j - REL_AT));
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_y", y, 32'd0);
        check("rst_gate", 32'(gate_open), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(CLOSED));
        @(negedge clk_48);
        rst_n = 1'b1;

        // silence below threshold keeps the gate shut
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_y", y, 32'd0);
            check("idle_gate", 32'(gate_open), 32'd0);
        end

        // constant 5000: open and ramp up
        x = 32'd5000;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 0) check("atk_env", 32'(dut.w_env), 32'd5000);
            check("atk_y", y, exp_atk_y(k));
            check("atk_gate", 32'(gate_open), (k >= 1) ? 32'd1 : 32'd0);
        end
        tick();
        tick();
        check("env_phase", 32'(dut.w_env), 32'd5000);

        // silence: decay, hold for 5 samples, release, close
        x = 32'd0;
        for (int j = 0; j <= FALL_AT; j++) begin
            tick();
            check("fall_gate", 32'(gate_open), (j < FALL_AT) ? 32'd1 : 32'd0);
            check("fall_state", 32'(dut.r_state), 32'(exp_fall_state(j)));
            check("fall_gain", 32'(dut.r_gain), exp_fall_gain(j));
            if (j == HOLD_AT) check("hold_load", 32'(dut.r_hold_cnt), 32'd4);
        end

        // reopen, then retrigger from HOLD with a single loud sample
        x = 32'd5000;
        repeat (13) tick();
        check("reopen_state", 32'(dut.r_state), 32'(OPEN));
        check("reopen_env", 32'(dut.w_env), 32'd5000);
        x = 32'd0;
        repeat (37) tick();
        check("hold2_state", 32'(dut.r_state), 32'(HOLD));
        check("hold2_cnt", 32'(dut.r_hold_cnt), 32'd4);
        tick();
        check("hold2_cnt_dec", 32'(dut.r_hold_cnt), 32'd3);
        x = 32'd5000;
        tick();
        check("retrig_wait_state", 32'(dut.r_state), 32'(HOLD));
        check("retrig_y", y, 32'd5000);
        x = 32'd100;
        hold_len = 12'd0;
        tick();
        check("retrig_state", 32'(dut.r_state), 32'(OPEN));
        check("retrig_gain", 32'(dut.r_gain), 32'd256);
        check("retrig_cnt", 32'(dut.r_hold_cnt), 32'd2);
        check("retrig_gate", 32'(gate_open), 32'd1);

        // decay again with hold_len=0: one HOLD sample, then RELEASE
        for (int j = 40; j <= 76; j++) begin
            tick();
            check("h0_y", y, 32'd100);
            check("h0_state", 32'(dut.r_state),
                  32'((j < 75) ? OPEN : ((j == 75) ? HOLD : RELEASE)));
        end

        // asynchronous reset in the middle of RELEASE
        #2 rst_n = 1'b0;
        #1;
        check("arst_y", y, 32'd0);
        check("arst_gate", 32'(gate_open), 32'd0);
        check("arst_state", 32'(dut.r_state), 32'(CLOSED));
        check("arst_gain", 32'(dut.r_gain), 32'd0);
        check("arst_env", 32'(dut.w_env), 32'd0);
        check("arst_cnt", 32'(dut.r_hold_cnt), 32'd0);

        // threshold 0: gate opens on the first edge after reset
        threshold = 16'd0;
        x = 32'd0;
        tick();
        check("arst_hold_y", y, 32'd0);
        @(negedge clk_48);
        rst_n = 1'b1;
        tick();
        check("thr0_state", 32'(dut.r_state), 32'(ATTACK));
        check("thr0_gate", 32'(gate_open), 32'd1);

        // bypass, upper input bits ignored, then resume gating
        en = 1'b0;
        x = 32'hFFFF8000;
        tick();
        check("byp_y_min", y, 32'hFFFF8000);
        check("byp_state", 32'(dut.r_state), 32'(OPEN));
        check("byp_gain", 32'(dut.r_gain), 32'd256);
        x = 32'h12347FFF;
        tick();
        check("byp_y_hi_ignored", y, 32'h00007FFF);
        en = 1'b1;
        x = 32'hFFFFEC78;
        tick();
        check("resume_y", y, 32'hFFFFEC78);
        check("resume_state", 32'(dut.r_state), 32'(OPEN));
        x = 32'd0;
        repeat (5) tick();
        check("thr0_stays_open", 32'(gate_open), 32'd1);

        // full-scale negative input saturates the envelope and opens at threshold 32767
        #2 rst_n = 1'b0;
        threshold = 16'd32767;
        x = 32'h00008000;
        @(negedge clk_48);
        rst_n = 1'b1;
        tick();
        check("sat_env", 32'(dut.w_env), 32'd32767);
        check("sat_gate0", 32'(gate_open), 32'd0);
        tick();
        check("sat_gate1", 32'(gate_open), 32'd1);
        check("sat_state", 32'(dut.r_state), 32'(ATTACK));
        check("sat_y", y, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noise_gate.md
NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have port clk_48  input  1  48 kHz sample clock, one sample per rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port x  input  32  distortion output; x[15:0] is a signed 16-bit sample and x[31:16] is ignored.
REQ-004 SHALL have port y  output  32  gated sample, signed 16-bit result sign-extended to 32 bits.
REQ-005 SHALL have port en  input  1  1 = gate active, 0 = bypass.
REQ-006 SHALL have port threshold  input  16  unsigned open level; close level = threshold>>1 (hysteresis).
REQ-007 SHALL have port hold_len  input  12  hold time in samples.
REQ-008 SHALL have port gate_open  output  1  high whenever state != CLOSED.

Function
REQ-009 SHALL take the input magnitude a = |x[15:0]|, saturating -32768 to 32767.
REQ-010 SHALL update the envelope each cycle: if a > env then env <= a, else env <= env - (env>>4).
REQ-011 SHALL implement FSM states CLOSED, ATTACK, OPEN, HOLD, RELEASE.
REQ-012 SHALL use gain as unsigned 9 bits, 0..256, with 256 = unity.
REQ-013 In CLOSED, gain SHALL be 0; env >= threshold SHALL move the FSM to ATTACK.
REQ-014 In ATTACK, gain SHALL increase by 32 per cycle, saturating at 256; reaching 256 SHALL move the FSM to OPEN; ATTACK SHALL NOT abort.
REQ-015 In OPEN, gain SHALL be 256; env < threshold>>1 SHALL move the FSM to HOLD and load hold_cnt <= hold_len.
REQ-016 In HOLD, env >= threshold SHALL move the FSM to OPEN (highest priority); otherwise hold_cnt == 0 SHALL move it to RELEASE; otherwise hold_cnt SHALL decrement.
REQ-017 HOLD SHALL last hold_len+1 cycles when not retriggered; hold_len=0 gives exactly 1 cycle.
REQ-018 In RELEASE, gain SHALL decrease by 1 per cycle; env >= threshold SHALL move the FSM to ATTACK from the current gain; gain reaching 0 SHALL move it to CLOSED.
REQ-019 FSM decisions SHALL use the registered env, i.e. the value before this cycle's update.
REQ-020 The output SHALL be registered: y <= sign-extended ((x[15:0] * gain) >>> 8), using a 25-bit signed product and the current-cycle gain; latency is 1 cycle.
REQ-021 With gain=256, y SHALL equal the sign-extended x[15:0] exactly; with gain=0, y SHALL be 0.
REQ-022 With en=0, y <= sign-extended x[15:0] (1-cycle latency), state <= OPEN and gain <= 256; env SHALL keep tracking.
REQ-023 A rising edge of en SHALL resume from OPEN with no output discontinuity.
REQ-024 threshold=0 SHALL keep the gate permanently opening (env >= 0 is always true).
REQ-025 threshold or hold_len changes SHALL take effect on the next cycle; a hold_len change SHALL NOT reload a running hold_cnt.

Reset
REQ-026 rst_n low SHALL immediately force y=0, gate_open=0, state=CLOSED, gain=0, env=0 and hold_cnt=0, in any state including mid-RELEASE.
REQ-027 After rst_n deasserts, the first update SHALL occur on the next clk_48 rising edge.

Configuration
REQ-028 Macro NOISE_GATE_RAMP_EN defined SHALL give the ramped ATTACK and RELEASE of REQ-014 and REQ-018.
REQ-029 With NOISE_GATE_RAMP_EN undefined, ATTACK SHALL set gain=256 and RELEASE SHALL set gain=0, each in one cycle; state transitions are otherwise identical.

Structure
REQ-030 Package pedal_pkg SHALL hold:
- sample_t (signed 16-bit);
- gate_state_t enum;
- GATE_GAIN_UNITY=256, GATE_ATK_STEP=32, GATE_REL_STEP=1, GATE_ENV_SHIFT=4.
REQ-031 Sub-module envelope_follower SHALL implement REQ-009 and REQ-010 and SHALL be clocked by clk_48 and reset by rst_n.

Verification
REQ-032 Reset then x=0, threshold=1000 for 50 cycles -> y=0 and gate_open=0 throughout.
REQ-033 threshold=1000, constant x=5000 -> gate_open high 1 cycle after env=5000; y steps 625, 1250, ... and equals 5000 exactly within 10 cycles (ramp build).
REQ-034 After REQ-033, hold_len=4, x=0 -> HOLD entered when env < 500; gate_open stays high for 5 HOLD cycles plus 256 RELEASE cycles, then falls.
REQ-035 During HOLD, x=5000 for 1 cycle -> state OPEN next cycle, gain stays 256, hold_cnt is not consulted.
REQ-036 en=0, x=0xFFFF8000 -> y=0xFFFF8000 one cycle later from any state; en=1, threshold=32767, x=-32768 -> env=32767 and the gate opens.
REQ-037 rst_n asserted mid-RELEASE between clock edges -> y=0 and gate_open=0 before the next edge.
